// File: rtl/trena_pkg.sv
// -----------------------------------------------------------------------------
// trena_pkg
// Shared definitions for the tape-measure transmission sequencer:
//   - ASCII constants used when formatting digits and the terminator
//   - state encoding of the sequencer FSM (also exported on db_estado)
//   - clog2 helper used to size the digit index
// -----------------------------------------------------------------------------
package trena_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_HASH = 7'h23;
  localparam logic [6:0] ASCII_ERRO = 7'h3F;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    AVALIA  = 4'd2,
    PARTIDA = 4'd3,
    ESPERA  = 4'd4,
    PROXIMO = 4'd5,
    FINAL   = 4'd6
  } estado_t;

  // Smallest r with 2**r >= value (value >= 2 in practice).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conversor_bcd_ascii.sv
// -----------------------------------------------------------------------------
// conversor_bcd_ascii
// Combinational BCD nibble to ASCII character.
//   nibble  in  4  BCD digit
//   ascii   out 7  '0'..'9' for a valid digit, '?' otherwise
//   valido  out 1  1 when nibble <= 9
// -----------------------------------------------------------------------------
module conversor_bcd_ascii
  import trena_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] ascii,
  output logic       valido
);

  assign valido = (nibble <= 4'd9);
  assign ascii  = valido ? (ASCII_ZERO + {3'b000, nibble}) : ASCII_ERRO;

endmodule

// File: rtl/trena_envio_medida.sv
// -----------------------------------------------------------------------------
// trena_envio_medida
// Sends a snapshot of a BCD distance measurement as ASCII characters followed
// by a terminator, one character per partida/pronto handshake with a serial
// transmitter.
//   clock       in   rising-edge system clock
//   reset       in   asynchronous, active-low reset
//   enviar      in   start request, only honoured when idle
//   medida      in   packed BCD measurement, nibble 0 = units
//   tx_pronto   in   done pulse from the transmitter
//   tx_partida  out  one-cycle start pulse to the transmitter
//   tx_dados    out  character being sent, stable while the transmitter works
//   ocupado     out  high whenever a transfer is in progress
//   fim         out  one-cycle pulse after the terminator has been sent
//   erro_bcd    out  sticky: a nibble above 9 was sent in this transfer
//   db_estado   out  current FSM state encoding
// -----------------------------------------------------------------------------
module trena_envio_medida
  import trena_pkg::*;
#(
  parameter int         DIGITOS       = 3,
  parameter logic [6:0] TERMINADOR    = ASCII_HASH,
  parameter bit         ORDEM_MSD     = 1'b1,
  parameter bit         SUPRIME_ZEROS = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enviar,
  input  logic [4*DIGITOS-1:0] medida,
  input  logic                 tx_pronto,
  output logic                 tx_partida,
  output logic [6:0]           tx_dados,
  output logic                 ocupado,
  output logic                 fim,
  output logic                 erro_bcd,
  output logic [3:0]           db_estado
);

  localparam int             IW     = clog2(DIGITOS + 1);
  localparam logic [IW-1:0]  ULTIMO = IW'(DIGITOS);

  estado_t              estado, proximo;
  logic [4*DIGITOS-1:0] snapshot;
  logic [IW-1:0]        indice;
  logic                 visto_nz;
  int                   posicao;
  logic [3:0]           nibble;
  logic [6:0]           ascii;
  logic                 valido;
  logic                 e_terminador;
  logic                 pula;

  // Digit selection: index counts characters in transmission order, posicao
  // is the nibble position that index maps to. The last index is the
  // terminator and selects no nibble.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    e_terminador = (indice == ULTIMO);
    posicao      = ORDEM_MSD ? (DIGITOS - 1 - int'(indice)) : int'(indice);
    nibble       = 4'd0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (i == posicao) nibble = snapshot[4*i +: 4];
    end
    // Leading zeros only make sense when the most significant digit comes
    // first; the units digit is never skipped so a zero reading still shows.
    pula = SUPRIME_ZEROS && ORDEM_MSD && !e_terminador && (nibble == 4'd0) &&
           !visto_nz && (posicao != 0);
  end

  conversor_bcd_ascii u_conversor (
    .nibble (nibble),
    .ascii  (ascii),
    .valido (valido)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo    = estado;
    tx_partida = 1'b0;
    fim        = 1'b0;
    case (estado)
      INICIAL: if (enviar) proximo = CARREGA;
      CARREGA: proximo = AVALIA;
      AVALIA:  proximo = pula ? PROXIMO : PARTIDA;
      PARTIDA: begin
        tx_partida = 1'b1;
        proximo    = ESPERA;
      end
      ESPERA:  if (tx_pronto) proximo = PROXIMO;
      PROXIMO: proximo = e_terminador ? FINAL : AVALIA;
      FINAL: begin
        fim     = 1'b1;
        proximo = INICIAL;
      end
      default: proximo = INICIAL;
    endcase
  end

  // Snapshot, index and flags. The snapshot is an ordinary register bank and
  // is cleared on reset like the rest of the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snapshot <= '0;
      indice   <= '0;
      visto_nz <= 1'b0;
      erro_bcd <= 1'b0;
      tx_dados <= '0;
    end else begin
      case (estado)
        CARREGA: begin
          snapshot <= medida;
          indice   <= '0;
          visto_nz <= 1'b0;
          erro_bcd <= 1'b0;
        end
        AVALIA: begin
          if (e_terminador) begin
            tx_dados <= TERMINADOR;
          end else begin
            tx_dados <= ascii;
            if (!valido) erro_bcd <= 1'b1;
          end
          if (!pula) visto_nz <= 1'b1;
        end
        PROXIMO: if (!e_terminador) indice <= indice + IW'(1);
        default: ;
      endcase
    end
  end

  assign ocupado   = (estado != INICIAL);
  assign db_estado = estado;

endmodule

// File: tb/tb_trena_envio_medida.sv
// -----------------------------------------------------------------------------
// tb_trena_envio_medida
// Three sequencer instances (defaults; leading-zero suppression; four digits
// least significant first) share one clock. One instance is exercised at a
// time through sel. Expected characters are queued when a transfer starts and
// compared when tx_partida fires; a responder plays the serial transmitter.
// -----------------------------------------------------------------------------
module tb_trena_envio_medida;

  localparam int N_PRONTO = 4;

  typedef struct packed {
    logic [6:0] ch;
    logic       erro;
  } esperado_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v   [3];
  logic        enviar_v  [3];
  logic        pronto_v  [3];
  logic        partida_v [3];
  logic        fim_v     [3];
  logic        ocup_v    [3];
  logic        erro_v    [3];
  logic [6:0]  dados_v   [3];
  logic [3:0]  estado_v  [3];
  logic [15:0] medida_v  [3];

  esperado_t fila[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  sel   = 0;
  int  last_evt = 0;
  int  fim_cnt  = 0;
  int  n_part   = 0;
  bit  lat_on   = 1'b1;
  bit  inj      = 1'b0;

  trena_envio_medida u_pad (
    .clock(clk), .reset(rst_n_v[0]), .enviar(enviar_v[0]),
    .medida(medida_v[0][11:0]), .tx_pronto(pronto_v[0]),
    .tx_partida(partida_v[0]), .tx_dados(dados_v[0]), .ocupado(ocup_v[0]),
    .fim(fim_v[0]), .erro_bcd(erro_v[0]), .db_estado(estado_v[0])
  );

  trena_envio_medida #(.SUPRIME_ZEROS(1'b1)) u_sup (
    .clock(clk), .reset(rst_n_v[1]), .enviar(enviar_v[1]),
    .medida(medida_v[1][11:0]), .tx_pronto(pronto_v[1]),
    .tx_partida(partida_v[1]), .tx_dados(dados_v[1]), .ocupado(ocup_v[1]),
    .fim(fim_v[1]), .erro_bcd(erro_v[1]), .db_estado(estado_v[1])
  );

  trena_envio_medida #(.DIGITOS(4), .ORDEM_MSD(1'b0)) u_lsd (
    .clock(clk), .reset(rst_n_v[2]), .enviar(enviar_v[2]),
    .medida(medida_v[2]), .tx_pronto(pronto_v[2]),
    .tx_partida(partida_v[2]), .tx_dados(dados_v[2]), .ocupado(ocup_v[2]),
    .fim(fim_v[2]), .erro_bcd(erro_v[2]), .db_estado(estado_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard side: every start pulse must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (rst_n_v[sel]) begin
      if (fim_v[sel]) fim_cnt++;
      if (partida_v[sel]) begin
        esperado_t e;
        n_part++;
        if (fila.size() == 0) begin
          check("caractere_extra", {25'd0, dados_v[sel]}, 32'hFFFF);
        end else begin
          e = fila.pop_front();
          check("tx_dados", {25'd0, dados_v[sel]}, {25'd0, e.ch});
          check("erro_bcd", {31'd0, erro_v[sel]}, {31'd0, e.erro});
          if (lat_on) check("latencia", cyc - last_evt, 3);
        end
      end
    end
  end

  // Transmitter model: tx_pronto N cycles after each start pulse. With inj
  // set, a stray tx_pronto is also shown while the sequencer is in PARTIDA.
  initial forever begin
    @(negedge clk);
    if (rst_n_v[sel] && partida_v[sel]) begin
      if (inj) begin
        pronto_v[sel] = 1'b1;
        @(posedge clk);
        #1 pronto_v[sel] = 1'b0;
        repeat (N_PRONTO - 1) @(posedge clk);
      end else begin
        repeat (N_PRONTO) @(posedge clk);
      end
      #1 pronto_v[sel] = 1'b1;
      last_evt = cyc;
      @(posedge clk);
      #1 pronto_v[sel] = 1'b0;
    end
  end

  task automatic push(input logic [6:0] ch, input logic erro);
    esperado_t e;
    e.ch   = ch;
    e.erro = erro;
    fila.push_back(e);
  endtask

  task automatic go(input logic [15:0] m);
    @(posedge clk);
    #1;
    medida_v[sel] = m;
    enviar_v[sel] = 1'b1;
    last_evt      = cyc;
    fim_cnt       = 0;
    n_part        = 0;
    @(posedge clk);
    #1 enviar_v[sel] = 1'b0;
  endtask

  task automatic wait_partidas(input int k);
    int n;
    n = 0;
    while (n_part < k && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n_part < k) check("timeout_partida", n_part, k);
  endtask

  task automatic wait_fim();
    int n;
    n = 0;
    while (fim_cnt == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (fim_cnt == 0) check("timeout_fim", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("fim_unico", fim_cnt, 1);
    check("fila_vazia", fila.size(), 0);
    check("ocupado_final", {31'd0, ocup_v[sel]}, 0);
    fila.delete();
  endtask

  task automatic check_repouso();
    check("rst_partida", {31'd0, partida_v[sel]}, 0);
    check("rst_dados",   {25'd0, dados_v[sel]}, 0);
    check("rst_ocupado", {31'd0, ocup_v[sel]}, 0);
    check("rst_fim",     {31'd0, fim_v[sel]}, 0);
    check("rst_erro",    {31'd0, erro_v[sel]}, 0);
    check("rst_estado",  {28'd0, estado_v[sel]}, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n_v[i]  = 1'b0;
      enviar_v[i] = 1'b0;
      pronto_v[i] = 1'b0;
      medida_v[i] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    check_repouso();
    for (int i = 0; i < 3; i++) rst_n_v[i] = 1'b1;

    // Basic transfer, MSD first, with start latency.
    push(7'h31, 0); push(7'h32, 0); push(7'h33, 0); push(7'h23, 0);
    go(16'h0123);
    wait_fim();
    check("erro_apos_123", {31'd0, erro_v[0]}, 0);

    // Invalid nibble: '?' is sent, flag is sticky past fim.
    push(7'h31, 0); push(7'h3F, 1); push(7'h35, 1); push(7'h23, 1);
    go(16'h01A5);
    wait_fim();
    check("erro_retido", {31'd0, erro_v[0]}, 1);

    // Next load clears the flag; medida change and enviar during ESPERA ignored.
    push(7'h31, 0); push(7'h32, 0); push(7'h33, 0); push(7'h23, 0);
    go(16'h0123);
    wait_partidas(1);
    #1;
    medida_v[0] = 16'h0999;
    enviar_v[0] = 1'b1;
    @(posedge clk);
    #1 enviar_v[0] = 1'b0;
    wait_fim();

    // Asynchronous reset while waiting for the second character.
    push(7'h31, 0); push(7'h32, 0); push(7'h33, 0); push(7'h23, 0);
    go(16'h0123);
    wait_partidas(2);
    #1 rst_n_v[0] = 1'b0;
    #1;
    check_repouso();
    fila.delete();
    @(posedge clk);
    #1 rst_n_v[0] = 1'b1;
    repeat (10) @(posedge clk);
    push(7'h34, 0); push(7'h35, 0); push(7'h36, 0); push(7'h23, 0);
    go(16'h0456);
    wait_fim();

    // Leading-zero suppression.
    sel    = 1;
    lat_on = 1'b0;
    push(7'h37, 0); push(7'h23, 0);
    go(16'h0007);
    wait_fim();
    push(7'h30, 0); push(7'h23, 0);
    go(16'h0000);
    wait_fim();
    push(7'h31, 0); push(7'h30, 0); push(7'h35, 0); push(7'h23, 0);
    go(16'h0105);
    wait_fim();

    // Four digits, LSD first, with a stray tx_pronto during every PARTIDA.
    sel    = 2;
    lat_on = 1'b1;
    inj    = 1'b1;
    push(7'h34, 0); push(7'h33, 0); push(7'h32, 0); push(7'h31, 0); push(7'h23, 0);
    go(16'h1234);
    wait_fim();
    inj = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trena_envio_medida.md
Name: trena_envio_medida

Overview:
- Parametrised transmission sequencer for the digital tape measure.
- Takes a snapshot of a BCD distance measurement of DIGITOS digits.
- Converts each digit to 7-bit ASCII and sends the characters, then a configurable terminator, one at a time through a 7O1 serial transmitter using its partida/pronto handshake.
- Sits between the HC-SR04 interface and tx_serial_7O1. It adds digit-order selection, leading-zero suppression and invalid-BCD flagging.

Parameters:
- DIGITOS, 3, number of BCD digits in medida (legal range 1..8).
- TERMINADOR, 7'h23, ASCII character sent after the last digit ("#").
- ORDEM_MSD, 1, 1 = most significant digit first; 0 = least significant first.
- SUPRIME_ZEROS, 0, 1 = leading zeros are skipped (the units digit is always sent).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enviar  in  1  start request, sampled only in INICIAL.
- medida  in  4*DIGITOS  packed BCD measurement; nibble 0 = units.
- tx_pronto  in  1  one-cycle done pulse from the serial transmitter.
- tx_partida  out  1  one-cycle start pulse to the transmitter.
- tx_dados  out  7  ASCII character; held stable from PARTIDA until tx_pronto is accepted.
- ocupado  out  1  high in every state except INICIAL.
- fim  out  1  one-cycle pulse when the terminator has been sent.
- erro_bcd  out  1  sticky flag: a nibble greater than 9 was sent.
- db_estado  out  4  current state encoding.

Behaviour:
- Reset (reset=0, async): state INICIAL, all outputs 0, snapshot/index/flags cleared.
- Reset is effective mid-transfer; the next enviar restarts from the first digit.
- States and encodings: INICIAL 0, CARREGA 1, AVALIA 2, PARTIDA 3, ESPERA 4, PROXIMO 5, FINAL 6. Unused codes go to INICIAL.
- INICIAL: if enviar=1, go to CARREGA. While in any other state, enviar is ignored.
- CARREGA:
  - Register medida into the snapshot; later changes to medida have no effect.
  - Index = 0, visto_nz = 0, erro_bcd = 0.
  - Go to AVALIA.
- AVALIA:
  - Index k < DIGITOS selects digit position p = DIGITOS-1-k if ORDEM_MSD=1, else p = k. Index k = DIGITOS selects TERMINADOR.
  - Digit to ASCII: value v ≤ 9 gives 7'h30+v; v > 9 gives 7'h3F ("?") and sets erro_bcd.
  - Character is registered into tx_dados.
  - Skip rule: SUPRIME_ZEROS=1 and ORDEM_MSD=1 and v=0 and visto_nz=0 and p≠0 → go to PROXIMO without transmitting.
  - Otherwise set visto_nz=1 and go to PARTIDA.
  - With ORDEM_MSD=0, suppression is disabled.
- PARTIDA: tx_partida=1 for exactly one cycle, then ESPERA.
- ESPERA:
  - Wait for tx_pronto=1, then PROXIMO.
  - tx_pronto is only sampled here; a pulse seen in PARTIDA or AVALIA is discarded.
- PROXIMO: if index = DIGITOS go to FINAL; else index+1 and go to AVALIA.
- FINAL: fim=1 for one cycle, then INICIAL. erro_bcd holds until the next CARREGA.
- Latency: enviar at cycle t gives tx_partida at t+3 (INICIAL at t, CARREGA t+1, AVALIA t+2, PARTIDA t+3). tx_pronto at cycle u gives the next tx_partida at u+3.
- Index width = clog2(DIGITOS+1). No wrap-around: the index never exceeds DIGITOS.
- Characters per transfer: DIGITOS+1 without suppression; minimum 2 with suppression (units digit + terminator).

Decomposition:
- trena_pkg holds:
  - ASCII constants: ASCII_ZERO 7'h30, ASCII_HASH 7'h23, ASCII_ERRO 7'h3F.
  - State encodings.
  - A function clog2.
- Sub-module conversor_bcd_ascii: combinational, 4-bit nibble → 7-bit ASCII plus valido flag. It is instantiated once on the selected nibble.
- FSM, index counter and snapshot register live in trena_envio_medida.
- The bench models tx_serial_7O1 as a responder that pulses tx_pronto N cycles after tx_partida.

Test Plan:
- Defaults, medida=12'h123, enviar pulse → tx_dados 0x31, 0x32, 0x33, 0x23 on four tx_partida pulses, first pulse 3 cycles after enviar; fim pulses once, erro_bcd=0.
- SUPRIME_ZEROS=1: medida=12'h007 → 0x37, 0x23 only. medida=12'h000 → 0x30, 0x23. medida=12'h105 → 0x31, 0x30, 0x35, 0x23 (the inner zero is kept).
- medida=12'h1A5 → 0x31, 0x3F, 0x35, 0x23; erro_bcd=1 after the second character, stays 1 after fim, clears on the next CARREGA.
- Change medida to 12'h999 and pulse enviar during ESPERA of the first character → sequence is still 0x31, 0x32, 0x33, 0x23 with exactly one fim.
- reset=0 during ESPERA of the second character → all outputs 0 immediately. A new enviar with medida=12'h456 gives 0x34, 0x35, 0x36, 0x23.
- ORDEM_MSD=0, DIGITOS=4, medida=16'h1234 → 0x34, 0x33, 0x32, 0x31, 0x23. A tx_pronto injected during PARTIDA is ignored; the sequence advances only on tx_pronto in ESPERA.
